// File: rtl/vme_mem_initiator_pkg.sv
// Shared definitions for the memory-bus initiator.
// - FSM state encoding (legacy localparam codes plus a typed enum over them)
// - ERR_PATTERN returned as read data when a transaction times out
// - cnt_w(): width of the BUSY wait counter for a given TIMEOUT
package vme_mem_initiator_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    BUSY = S_BUSY,
    RESP = S_RESP
  } state_e;

  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

  localparam int unsigned TCNT_W = 8;

  // Wait counter must be able to hold the value TIMEOUT itself.
  function automatic int unsigned cnt_w(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/vme_mem_initiator_if.sv
// Command/response port plus strobe/done register-bank bus.
// master: the initiator (drives cmd_ready, rsp_*, VMEAddr/VMEWrData/VMERdMem/VMEWrMem)
// slave : host command source and register-bank side (drives everything else)
interface vme_mem_initiator_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] VMEAddr;
  logic [DATA_W-1:0] VMEWrData;
  logic              VMERdMem;
  logic              VMEWrMem;
  logic [DATA_W-1:0] VMERdData;
  logic              VMERdDone;
  logic              VMEWrDone;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
           VMERdData, VMERdDone, VMEWrDone,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           VMEAddr, VMEWrData, VMERdMem, VMEWrMem
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
           VMERdData, VMERdDone, VMEWrDone,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           VMEAddr, VMEWrData, VMERdMem, VMEWrMem
  );

endinterface

// File: rtl/vme_mem_initiator.sv
// Single-outstanding bus master for the strobe/done register-bank bus.
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   bus          vme_mem_initiator_if.master: cmd (valid/ready), rsp (valid/ready), VME bus
//   timeout_cnt  saturating count of timed-out transactions
module vme_mem_initiator
  import vme_mem_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vme_mem_initiator_if.master   bus,
  output logic [TCNT_W-1:0]     timeout_cnt
);

  localparam int unsigned CNT_W = cnt_w(TIMEOUT);

  state_e              state_q, state_d;
  logic                ready_q;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_mem_q, rd_mem_d;
  logic                wr_mem_q, wr_mem_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                cmd_ready_int;
  logic                done_match;

  // ready_q keeps cmd_ready low during the reset cycle itself.
  assign cmd_ready_int = (state_q == IDLE) && ready_q;
  assign done_match    = we_q ? bus.VMEWrDone : bus.VMERdDone;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_mem_q    <= 1'b0;
      wr_mem_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_mem_q    <= rd_mem_d;
      wr_mem_q    <= wr_mem_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tcnt_q      <= tcnt_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_mem_d    = 1'b0;
    wr_mem_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tcnt_d      = tcnt_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_int) begin
          we_d     = bus.cmd_we;
          addr_d   = bus.cmd_addr;
          wdata_d  = bus.cmd_wdata;
          rd_mem_d = !bus.cmd_we;
          wr_mem_d = bus.cmd_we;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // A matching done takes priority over an expiring counter.
        if (done_match) begin
          rsp_rdata_d = we_q ? '0 : bus.VMERdData;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rsp_rdata_d = DATA_W'(ERR_PATTERN);
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          if (tcnt_q != {TCNT_W{1'b1}}) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_int;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.VMEAddr   = addr_q;
  assign bus.VMEWrData = wdata_q;
  assign bus.VMERdMem  = rd_mem_q;
  assign bus.VMEWrMem  = wr_mem_q;
  assign timeout_cnt   = tcnt_q;

endmodule

// File: tb/tb_vme_mem_initiator.sv
// Bench for vme_mem_initiator (TIMEOUT = 4): table-driven single transactions
// against a register-bank slave model with programmable done latency, plus
// hand-written sequences for late done, back-to-back, wrong done and reset.
module tb_vme_mem_initiator;
  import vme_mem_initiator_pkg::*;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 4;

  logic clk;
  logic rst_n;
  logic [TCNT_W-1:0] timeout_cnt;

  vme_mem_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vme_mem_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.master),
    .timeout_cnt (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave model: answers a strobe sl_lat cycles later (0 = same cycle).
  // Read data is {16'h1234, address}. Manual done lines are ORed in.
  bit          sl_en;
  int          sl_lat;
  logic        sl_rd_done, sl_wr_done;
  logic [31:0] sl_rdata;
  logic        man_rd_done, man_wr_done;
  logic [31:0] man_rdata;

  assign bus.VMERdDone = sl_rd_done | man_rd_done;
  assign bus.VMEWrDone = sl_wr_done | man_wr_done;
  assign bus.VMERdData = man_rd_done ? man_rdata : sl_rdata;

  initial begin
    bit is_rd;
    sl_rd_done = 1'b0;
    sl_wr_done = 1'b0;
    sl_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      if (sl_en && (bus.VMERdMem || bus.VMEWrMem)) begin
        is_rd = bus.VMERdMem;
        repeat (sl_lat) @(negedge clk);
        if (is_rd) begin
          sl_rdata   = {16'h1234, bus.VMEAddr};
          sl_rd_done = 1'b1;
        end else begin
          sl_wr_done = 1'b1;
        end
        @(negedge clk);
        sl_rd_done = 1'b0;
        sl_wr_done = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          lat;      // -1: slave never answers
    int          exp_cyc;  // cycles from acceptance to rsp_valid
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];
  int   exp_tcnt = 0;

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    bit seen;
    int strb;
    int leak;
    string tag;
    tag = $sformatf("v%0d", idx);
    sl_en  = (v.lat >= 0);
    sl_lat = (v.lat < 0) ? 0 : v.lat;
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = v.we;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 1;
    chk({tag, "_addr"}, 32'(bus.VMEAddr), 32'(v.addr));
    chk({tag, "_wdata"}, bus.VMEWrData, v.wdata);
    strb = 0;
    leak = 0;
    seen = 1'b0;
    while (n < 30 && !seen) begin
      if (v.we ? bus.VMEWrMem : bus.VMERdMem) strb++;
      if (v.we ? bus.VMERdMem : bus.VMEWrMem) strb += 100;
      if (bus.cmd_ready) leak++;
      if (bus.rsp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'(v.exp_cyc));
    chk({tag, "_strobe_pulses"}, 32'(strb), 32'd1);
    chk({tag, "_ready_low"}, 32'(leak), 32'd0);
    chk({tag, "_rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    if (v.exp_err) exp_tcnt++;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_dropped"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'(exp_tcnt));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int leak;
    int bad;
    int si, ri, ci, hv;
    int acc[3];
    int stb[3];
    int hs[3];
    logic [15:0] b2b_addr[3];
    logic [31:0] b2b_exp[3];

    vecs[0] = '{1'b0, 16'h5678, 32'h0BAD_0000, 2, 4, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 16'h0004, 32'hCAFE_0001, 0, 2, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b0, 16'h00FF, 32'h0000_0000, 0, 2, 32'h1234_00FF, 1'b0};
    vecs[3] = '{1'b1, 16'h8000, 32'h5555_AAAA, 3, 5, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b0, 16'h0042, 32'h0000_0000, -1, 6, 32'hDEAD_BEEF, 1'b1};
    vecs[5] = '{1'b1, 16'hFFFF, 32'h1111_2222, -1, 6, 32'hDEAD_BEEF, 1'b1};
    vecs[6] = '{1'b0, 16'h0001, 32'h0000_0000, 4, 6, 32'h1234_0001, 1'b0};
    vecs[7] = '{1'b0, 16'h0002, 32'h0000_0000, 5, 6, 32'hDEAD_BEEF, 1'b1};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    man_rd_done = 1'b0;
    man_wr_done = 1'b0;
    man_rdata   = 32'h0;
    sl_en  = 1'b0;
    sl_lat = 0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_strobes", 32'({bus.VMERdMem, bus.VMEWrMem}), 32'd0);
    chk("rst_addr", 32'(bus.VMEAddr), 32'd0);
    chk("rst_wrdata", bus.VMEWrData, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_tcnt", 32'(timeout_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Timeout with response stalled; late RdDone inside RESP and after.
    sl_en = 1'b0;
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 16'h0077;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 1;
    while (n < 30 && !bus.rsp_valid) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", 32'(n), 32'd6);
    repeat (3) @(negedge clk);
    man_rdata   = 32'h0000_0055;
    man_rd_done = 1'b1;
    @(negedge clk);
    man_rd_done = 1'b0;
    chk("to_late_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    chk("to_late_err", 32'(bus.rsp_err), 32'd1);
    chk("to_tcnt", 32'(timeout_cnt), 32'(exp_tcnt + 1));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    man_rd_done = 1'b1;
    @(negedge clk);
    man_rd_done = 1'b0;
    leak = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid || !bus.cmd_ready) leak++;
    end
    chk("to_late_done_ignored", 32'(leak), 32'd0);

    // Back-to-back reads, first response stalled 5 cycles.
    sl_en  = 1'b1;
    sl_lat = 0;
    b2b_addr[0] = 16'h0010; b2b_exp[0] = 32'h1234_0010;
    b2b_addr[1] = 16'h0020; b2b_exp[1] = 32'h1234_0020;
    b2b_addr[2] = 16'h0030; b2b_exp[2] = 32'h1234_0030;
    for (int k = 0; k < 3; k++) begin
      acc[k] = -1; stb[k] = -1; hs[k] = -1;
    end
    si = 0; ri = 0; ci = 0; hv = 0; leak = 0; bad = 0;
    for (int c = 0; c < 60 && ri < 3; c++) begin
      @(negedge clk);
      if (bus.VMERdMem && si < 3) begin
        stb[si] = c;
        si++;
      end
      if ((bus.VMERdMem || bus.rsp_valid) && bus.cmd_ready) leak++;
      if (bus.rsp_valid) begin
        hv++;
        if (bus.rsp_rdata !== b2b_exp[ri]) bad++;
        bus.rsp_ready = (ri != 0) || (hv > 5);
        if (bus.rsp_ready) begin
          hs[ri] = c;
          ri++;
          hv = 0;
        end
      end else begin
        bus.rsp_ready = 1'b0;
        hv = 0;
      end
      if (ci < 3) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = b2b_addr[ci];
        if (bus.cmd_ready) begin
          acc[ci] = c;
          ci++;
        end
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("b2b_responses", 32'(ri), 32'd3);
    chk("b2b_data_order", 32'(bad), 32'd0);
    chk("b2b_ready_low", 32'(leak), 32'd0);
    chk("b2b_stall_len", 32'(hs[0] - acc[0]), 32'd7);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b_strobe%0d", k), 32'(stb[k] - acc[k]), 32'd1);
    end
    for (int k = 1; k < 3; k++) begin
      chk($sformatf("b2b_accept%0d", k), 32'(acc[k] - hs[k-1]), 32'd1);
    end

    // Non-matching WrDone during a read, RdDone one cycle later.
    sl_en = 1'b0;
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 16'h0100;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    man_wr_done = 1'b1;
    @(negedge clk);
    man_wr_done = 1'b0;
    chk("wd_ignored", 32'(bus.rsp_valid), 32'd0);
    man_rdata   = 32'h0000_00AA;
    man_rd_done = 1'b1;
    @(negedge clk);
    man_rd_done = 1'b0;
    chk("wd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wd_rdata", bus.rsp_rdata, 32'h0000_00AA);
    chk("wd_err", 32'(bus.rsp_err), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // Reset while BUSY, followed by a done.
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 16'h0200;
    bus.cmd_wdata = 32'h7777_7777;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    man_rdata   = 32'h0000_0033;
    man_rd_done = 1'b1;
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_addr", 32'(bus.VMEAddr), 32'd0);
    chk("mid_rst_wrdata", bus.VMEWrData, 32'd0);
    chk("mid_rst_tcnt", 32'(timeout_cnt), 32'd0);
    @(negedge clk);
    man_rd_done = 1'b0;
    chk("mid_rst_ready_after", 32'(bus.cmd_ready), 32'd1);
    leak = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.VMERdMem || bus.VMEWrMem) leak++;
    end
    chk("mid_rst_no_rsp", 32'(leak), 32'd0);
    chk("mid_rst_rdata", bus.rsp_rdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vme_mem_initiator.md
Name: vme_mem_initiator

Overview:
Bus-master end of the team's memory-style register-bank interface: the strobe (RdMem/WrMem) / done (RdDone/WrDone) bus that the generated register banks answer.
- Accepts single read/write commands over a valid/ready port and issues exactly one bus transaction per command.
- Waits for the matching done, with a timeout.
- Returns read data, or an error flag, over a valid/ready response port.
- Sits between a host-side command source (UART/PCIe bridge, test sequencer) and one or more register banks.

Parameters:
ADDR_W, 16, width of cmd_addr / VMEAddr
DATA_W, 32, data width on both sides
TIMEOUT, 255, BUSY cycles without the matching done before an error response; must be >= 1

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_we  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_W  read data; 0 for writes; ERR_PATTERN on timeout
rsp_err  out  1  1 = transaction timed out
VMEAddr  out  ADDR_W  bus address
VMEWrData  out  DATA_W  bus write data
VMERdMem  out  1  read strobe, one-cycle pulse
VMEWrMem  out  1  write strobe, one-cycle pulse
VMERdData  in  DATA_W  slave read data, valid while VMERdDone = 1
VMERdDone  in  1  read completion
VMEWrDone  in  1  write completion
timeout_cnt  out  8  saturating count of timed-out transactions

Behaviour:
- Reset is rst_n: synchronous, active-low.
- Reset values:
  - state IDLE
  - cmd_ready = 0 in the reset cycle, 1 from the first cycle after reset
  - rsp_valid, rsp_err, VMERdMem, VMEWrMem = 0
  - rsp_rdata, VMEAddr, VMEWrData = 0
  - timeout_cnt = 0
- All outputs are registered except cmd_ready, which is decoded from state: cmd_ready = (state == IDLE).
- FSM states: IDLE, BUSY, RESP.
  - IDLE: on cmd_valid, latch we/addr/wdata into VMEAddr/VMEWrData; in the next cycle raise VMERdMem (we = 0) or VMEWrMem (we = 1) for exactly one cycle; go to BUSY. The wait counter clears to 0.
  - BUSY: the strobe is high only in the first BUSY cycle. The matching done (RdDone for reads, WrDone for writes) is accepted in any BUSY cycle, including the strobe cycle, which covers zero-latency slaves.
    - Read done: rsp_rdata <= VMERdData, rsp_err <= 0.
    - Write done: rsp_rdata <= 0, rsp_err <= 0.
    - Either case: go to RESP.
    - Without a matching done: the counter increments. If counter == TIMEOUT, set rsp_err <= 1, rsp_rdata <= ERR_PATTERN, increment timeout_cnt (saturating at 255), and go to RESP.
    - Done and timeout in the same cycle: done wins.
  - RESP: rsp_valid = 1 and the response is held stable until rsp_ready; then return to IDLE.
- Latency: command accepted in cycle N, strobe in N+1, done in cycle D >= N+1, rsp_valid in D+1.
- Timeout: with no done, rsp_valid rises at N+TIMEOUT+2.
- Throughput: with a zero-latency slave and rsp_ready tied high, one command per 3 cycles.
- VMEAddr and VMEWrData are stable from the strobe cycle until the next command is accepted.
- Ignored done pulses:
  - the non-matching done in BUSY (e.g. WrDone during a read)
  - any done in IDLE or RESP, including a late done after a timeout
  - none of these alter state or data
- Reset mid-transaction: return to IDLE and drop the pending response; any done arriving afterwards is ignored.
- Only one transaction is outstanding at a time; no command is accepted while in BUSY or RESP.

Decomposition:
- Shared package holds:
  - state enum (IDLE, BUSY, RESP)
  - ERR_PATTERN = 32'hDEAD_BEEF (truncated or zero-extended to DATA_W)
  - timeout counter width, derived from TIMEOUT
- No sub-module is needed; the FSM plus counter stays a single module.
- Bench pairs the block with a register-bank slave model with programmable done latency.

Test Plan:
1. Read, done latency 2, VMERdData = 32'h1234_5678 -> one-cycle VMERdMem pulse with VMEAddr = cmd_addr; rsp_valid 4 cycles after acceptance; rsp_rdata = 32'h1234_5678; rsp_err = 0.
2. Write addr 16'h0004, data 32'hCAFE_0001, done in the strobe cycle -> VMEWrMem one cycle; VMEWrData = 32'hCAFE_0001; rsp_valid at N+2; rsp_rdata = 0.
3. Read to a slave that never answers, TIMEOUT = 4 -> rsp_valid at N+6; rsp_err = 1; rsp_rdata = 32'hDEAD_BEEF; timeout_cnt = 1. A late RdDone 3 cycles later is ignored (state IDLE, no second response).
4. Back-to-back: 3 commands with cmd_valid held high and rsp_ready low for 5 cycles on the first response -> cmd_ready low during BUSY/RESP; strobes at N+1, then 1 cycle after each rsp handshake; responses in order.
5. WrDone pulse during a read in BUSY, RdDone one cycle later with data 32'h0000_00AA -> WrDone ignored; rsp_rdata = 32'h0000_00AA.
6. rst_n low for 1 cycle while in BUSY, followed by a done -> all outputs at reset values; no rsp_valid; cmd_ready = 1 one cycle after rst_n rises.
